spi_slave_reg_bridge: RTL

Register-access bridge directly downstream of the SPI slave: consumes each received byte (`rx_data`/`rx_done`), decodes a command/address/data protocol, and maintains a small register file. It also drives the slave's transmit word (`tx_data`) so that read data is shifted out to the master with no turnaround byte. A host-side port lets on-chip logic observe the registers and update them.

---
 rtl/spi_bridge_pkg.sv | 15 +
 rtl/spi_bridge_regfile.sv | 42 ++++
 rtl/spi_slave_reg_bridge.sv | 106 ++++++++++
 3 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI register bridge.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    S_CMD = 2'd0,
    S_WR  = 2'd1,
    S_RD  = 2'd2
  } state_t;

  localparam int BITS_SIZE_DEF = 8;
  localparam int ADDR_W_DEF    = 4;
  localparam int RW_BIT        = BITS_SIZE_DEF - 1;
  localparam int TX_IDLE       = 0;

endpackage

// File: rtl/spi_bridge_regfile.sv
// Flop-based register file: SPI and host write ports (SPI wins on a shared address),
// one combinational read port, and the whole file flattened onto reg_q.
module spi_bridge_regfile #(
  parameter int bits_size = 8,
  parameter int addr_w    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              spi_we,
  input  logic [addr_w-1:0]                 spi_addr,
  input  logic [bits_size-1:0]              spi_wdata,
  input  logic                              host_we,
  input  logic [addr_w-1:0]                 host_addr,
  input  logic [bits_size-1:0]              host_wdata,
  input  logic [addr_w-1:0]                 rd_addr,
  output logic [bits_size-1:0]              rd_data,
  output logic [(2**addr_w)*bits_size-1:0]  reg_q
);

  localparam int NUM_REGS = 2 ** addr_w;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [bits_size-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= '0;
        end else if (spi_we && spi_addr == addr_w'(gi)) begin
          q_reg <= spi_wdata;
        end else if (host_we && host_addr == addr_w'(gi)) begin
          q_reg <= host_wdata;
        end
      end

      assign reg_q[gi*bits_size +: bits_size] = q_reg;
    end
  endgenerate

  assign rd_data = reg_q[rd_addr*bits_size +: bits_size];

endmodule

// File: rtl/spi_slave_reg_bridge.sv
// Decodes command/address/data bytes from the SPI slave into register accesses
// and presents read data on tx_data in the same cycle the byte completes.
module spi_slave_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int bits_size = BITS_SIZE_DEF,
  parameter int addr_w    = ADDR_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ss,
  input  logic [bits_size-1:0]              rx_data,
  input  logic                              rx_done,
  output logic [bits_size-1:0]              tx_data,
  output logic [(2**addr_w)*bits_size-1:0]  reg_q,
  output logic                              wr_stb,
  output logic [addr_w-1:0]                 wr_addr,
  input  logic                              host_we,
  input  logic [addr_w-1:0]                 host_addr,
  input  logic [bits_size-1:0]              host_wdata,
  output logic                              busy
);

  localparam int RW_POS = RW_BIT - BITS_SIZE_DEF + bits_size;

  state_t               state_reg, state_next;
  logic                 rx_done_d_reg;
  logic                 rx_rise;
  logic                 cmd_read;
  logic [addr_w-1:0]    addr_reg, addr_next;
  logic [addr_w-1:0]    rd_addr;
  logic [bits_size-1:0] rd_data;
  logic [bits_size-1:0] tx_q_reg;
  logic                 rd_sel;
  logic                 spi_we;
  logic                 wr_stb_reg;
  logic [addr_w-1:0]    wr_addr_reg;

  assign rx_rise  = rx_done & ~rx_done_d_reg;
  assign cmd_read = rx_data[RW_POS];

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      S_CMD: begin
        if (rx_rise) begin
          addr_next  = rx_data[addr_w-1:0];
          state_next = cmd_read ? S_RD : S_WR;
        end
      end
      S_WR, S_RD: begin
        if (rx_rise) addr_next = addr_reg + 1'b1;
      end
      default: state_next = S_CMD;
    endcase
    // A byte completing alongside ss high is still applied above; only the state resets.
    if (ss) state_next = S_CMD;
  end

  assign spi_we  = (state_reg == S_WR) && rx_rise;
  assign rd_addr = (state_reg == S_CMD) ? rx_data[addr_w-1:0] : addr_reg + 1'b1;
  assign rd_sel  = rx_rise && (((state_reg == S_CMD) && cmd_read) || (state_reg == S_RD));
  assign tx_data = rd_sel ? rd_data : tx_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_CMD;
      addr_reg      <= '0;
      rx_done_d_reg <= 1'b0;
      tx_q_reg      <= bits_size'(TX_IDLE);
      wr_stb_reg    <= 1'b0;
      wr_addr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      rx_done_d_reg <= rx_done;
      // Holding tx_data between bytes; idle and command phases always shift zeros.
      tx_q_reg      <= (state_next == S_CMD) ? bits_size'(TX_IDLE) : tx_data;
      wr_stb_reg    <= spi_we;
      if (spi_we) wr_addr_reg <= addr_reg;
    end
  end

  assign wr_stb  = wr_stb_reg;
  assign wr_addr = wr_addr_reg;
  assign busy    = (state_reg != S_CMD);

  spi_bridge_regfile #(
    .bits_size (bits_size),
    .addr_w    (addr_w)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .spi_we     (spi_we),
    .spi_addr   (addr_reg),
    .spi_wdata  (rx_data),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .reg_q      (reg_q)
  );

endmodule
